// File: rtl/kianv_wb_pkg.sv
// Shared widths and the write-back payload type used by the arbiter and its
// long-latency result buffer.
package kianv_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries buffering long-latency results
// while the core datapath owns the register-file write port.
module wb_fifo
  import kianv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core datapath first, buffered long-latency
// results otherwise, plus a pending-destination scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_we,
  input  logic [4:0]      core_rd,
  input  logic [XLEN-1:0] core_wd,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wd,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_rd,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic            lu_pending
);
  import kianv_wb_pkg::*;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                bypass;
  logic                lu_acc;
  logic                sel_valid;
  logic                sel_lu;
  wb_entry_t           head;
  wb_entry_t           lu_entry;
  wb_entry_t           sel;
  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_next;
  logic                src_lu;

  assign lu_entry = '{rd: lu_rd, wd: lu_wd};
  // No fall-through when full, and nothing accepted while in reset.
  assign lu_ready = !full && !rst;
  assign lu_acc   = lu_valid && lu_ready;
  assign push     = lu_acc && !bypass;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (lu_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Strict priority: core, then buffered head, then direct bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_lu    = 1'b0;
    sel       = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (core_we) begin
      sel_valid = 1'b1;
      sel       = '{rd: core_rd, wd: core_wd};
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_lu    = 1'b1;
      sel       = head;
      pop       = 1'b1;
    end else if (lu_acc) begin
      sel_valid = 1'b1;
      sel_lu    = 1'b1;
      sel       = lu_entry;
      bypass    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we  <= 1'b0;
      rf_a3  <= '0;
      rf_wd  <= '0;
      src_lu <= 1'b0;
    end else begin
      rf_we  <= sel_valid && (sel.rd != '0);
      src_lu <= sel_valid && sel_lu && (sel.rd != '0);
      if (sel_valid) begin
        rf_a3 <= sel.rd;
        rf_wd <= sel.wd;
      end
    end
  end

  // Clear on commit of an lu-sourced write; a same-edge issue re-sets the bit.
  always_comb begin
    sb_next = sb;
    if (rf_we && src_lu) sb_next[rf_a3] = 1'b0;
    if (issue_valid && (issue_rd != '0)) sb_next[issue_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  assign busy_rs1   = sb[rs1];
  assign busy_rs2   = sb[rs2];
  assign busy_rd    = sb[issue_rd];
  assign lu_pending = (|sb) || !empty;

  a_issue_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(issue_valid && (issue_rd != '0) && sb[issue_rd]));

  a_core_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(core_we && (core_rd != '0) && sb[core_rd]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, core writes, scoreboard,
// contention through the buffer, x0 handling and reset mid-operation.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_rd;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        lu_pending;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .FIFO_DEPTH (2),
    .XLEN       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_we     (core_we),
    .core_rd     (core_rd),
    .core_wd     (core_wd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_wd       (lu_wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .busy_rd     (busy_rd),
    .rf_we       (rf_we),
    .rf_a3       (rf_a3),
    .rf_wd       (rf_wd),
    .lu_pending  (lu_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_we     = 1'b0;
    core_rd     = '0;
    core_wd     = '0;
    lu_valid    = 1'b0;
    lu_rd       = '0;
    lu_wd       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1      = 5'd1;
    rs2      = 5'd2;
    rst      = 1'b1;
    lu_valid = 1'b1;
    lu_rd    = 5'd6;
    lu_wd    = 32'h1111_2222;
    step();
    step();
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got=%b exp=0", lu_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_a3 !== 5'd0 || rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_addr_data got=%0d/%h exp=0/0", rf_a3, rf_wd); end
    checks++; if ({busy_rs1, busy_rs2, busy_rd, lu_pending} !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b exp=0000", {busy_rs1, busy_rs2, busy_rd, lu_pending}); end
    rst      = 1'b0;
    lu_valid = 1'b0;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", lu_ready); end
    step();
  endtask

  task automatic test_core_write();
    core_we = 1'b1;
    core_rd = 5'd5;
    core_wd = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL core_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_a3, rf_wd); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL core_write_done got=%b exp=0", rf_we); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1         = 5'd7;
    #1;
    checks++; if (busy_rs1 !== 1'b0) begin errors++; $display("FAIL sb_no_forward got=%b exp=0", busy_rs1); end
    step();
    issue_valid = 1'b0;
    checks++; if (busy_rs1 !== 1'b1 || lu_pending !== 1'b1) begin errors++; $display("FAIL sb_set got=%b/%b exp=1/1", busy_rs1, lu_pending); end
    step(); step(); step();
    checks++; if (busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_hold got=%b exp=1", busy_rs1); end
    step();
    lu_valid = 1'b1;
    lu_rd    = 5'd7;
    lu_wd    = 32'h1234_5678;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL sb_lu_ready got=%b exp=1", lu_ready); end
    step();
    lu_valid = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'd7 || rf_wd !== 32'h1234_5678) begin errors++; $display("FAIL sb_bypass_write got=%b/%0d/%h exp=1/7/12345678", rf_we, rf_a3, rf_wd); end
    checks++; if (busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_busy_during_commit got=%b exp=1", busy_rs1); end
    step();
    checks++; if (busy_rs1 !== 1'b0 || rf_we !== 1'b0 || lu_pending !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%b/%b/%b exp=0/0/0", busy_rs1, rf_we, lu_pending); end
  endtask

  task automatic test_contention();
    logic        exp_ready [9];
    logic        exp_we    [9];
    logic [4:0]  exp_a3    [9];
    logic [31:0] exp_wd;
    exp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_we    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_a3    = '{5'd0, 5'd20, 5'd21, 5'd22, 5'd23, 5'd3, 5'd4, 5'd9, 5'd0};
    for (int r = 0; r < 3; r++) begin
      issue_valid = 1'b1;
      issue_rd    = (r == 0) ? 5'd3 : (r == 1) ? 5'd4 : 5'd9;
      step();
    end
    idle_inputs();
    for (int c = 0; c < 9; c++) begin
      exp_wd = (c >= 1 && c <= 4) ? (32'hC000_0000 + 32'(c - 1)) : (32'hA000_0000 + 32'(exp_a3[c]));
      checks++;
      if (rf_we !== exp_we[c] || (exp_we[c] && (rf_a3 !== exp_a3[c] || rf_wd !== exp_wd))) begin
        errors++;
        $display("FAIL contention_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_we, rf_a3, rf_wd, exp_we[c], exp_a3[c], exp_wd);
      end
      core_we  = (c < 4);
      core_rd  = 5'(20 + c);
      core_wd  = 32'hC000_0000 + 32'(c);
      lu_valid = (c < 6);
      lu_rd    = (c == 0) ? 5'd3 : (c == 1) ? 5'd4 : 5'd9;
      lu_wd    = 32'hA000_0000 + 32'(lu_rd);
      #1;
      checks++; if (lu_ready !== exp_ready[c]) begin errors++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, lu_ready, exp_ready[c]); end
      step();
    end
    idle_inputs();
    checks++; if (lu_pending !== 1'b0) begin errors++; $display("FAIL contention_drained got=%b exp=0", lu_pending); end
  endtask

  task automatic test_x0();
    lu_valid    = 1'b1;
    lu_rd       = 5'd0;
    lu_wd       = 32'hFFFF_FFFF;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    #1;
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", lu_ready); end
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b0 || lu_pending !== 1'b0 || busy_rd !== 1'b0) begin errors++; $display("FAIL x0_no_write got=%b/%b/%b exp=0/0/0", rf_we, lu_pending, busy_rd); end
    step();
    checks++; if (rf_we !== 1'b0 || lu_pending !== 1'b0) begin errors++; $display("FAIL x0_quiet got=%b/%b exp=0/0", rf_we, lu_pending); end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 2; r++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(12 + r);
      step();
    end
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      core_we  = 1'b1;
      core_rd  = 5'(25 + c);
      core_wd  = 32'hB000_0000 + 32'(c);
      lu_valid = 1'b1;
      lu_rd    = 5'(12 + c);
      lu_wd    = 32'hE000_0000 + 32'(c);
      step();
    end
    lu_valid = 1'b0;
    core_rd  = 5'd27;
    rs1      = 5'd12;
    rs2      = 5'd13;
    checks++; if (lu_pending !== 1'b1 || lu_ready !== 1'b0) begin errors++; $display("FAIL mid_prefill got=%b/%b exp=1/0", lu_pending, lu_ready); end
    rst = 1'b1;
    step();
    checks++; if (rf_we !== 1'b0 || lu_pending !== 1'b0 || busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%b/%b/%b exp=0/0/0/0", rf_we, lu_pending, busy_rs1, busy_rs2); end
    rst = 1'b0;
    idle_inputs();
    step();
    checks++; if (rf_we !== 1'b0 || lu_pending !== 1'b0) begin errors++; $display("FAIL mid_after_release got=%b/%b exp=0/0", rf_we, lu_pending); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_no_late_write got=%b exp=0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_scoreboard();
    test_contention();
    test_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
